// File: rtl/multi_port_collector.sv
// multi_port_collector
// Reader-side endpoint for the multi-cycle VALID/CONSUMED port protocol.
// Collects one token per producer channel and holds it. When every channel
// holds a token and the normal-domain side is ready, it releases the whole
// bundle in a single-cycle step. A channel whose slot is being released can
// be refilled in that same cycle, so streaming runs at one step per cycle.
module multi_port_collector #(
  parameter int width  = 8,
  parameter int nports = 2
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [nports*width-1:0]   IN_DATA,
  input  logic [nports-1:0]         IN_VALID,
  output logic [nports-1:0]         IN_CONSUMED,
  input  logic                      STEP_EN,
  output logic                      OUT_READY,
  output logic                      OUT_FIRE,
  output logic [nports*width-1:0]   OUT_DATA,
  output logic [15:0]               STEP_COUNT
);

  logic [nports-1:0]       got_q;
  logic [nports-1:0]       got_d;
  logic [nports*width-1:0] hold_q;
  logic [nports*width-1:0] hold_d;
  logic [15:0]             stepCount_q;
  logic [15:0]             stepCount_d;

  logic                    bundleReady;
  logic                    stepFire;
  logic [nports-1:0]       accept;

  // Handshake decode: the bundle is complete when every slot is filled; a
  // step fires only out of reset with the downstream side ready; a channel
  // is accepted when its slot is empty or is being emptied by this step.
  always_comb begin
    bundleReady = &got_q;
    stepFire    = bundleReady & STEP_EN & RST_N;
    accept      = {nports{RST_N}} & IN_VALID & (~got_q | {nports{stepFire}});
  end

  // Next-state: accepted tokens load their slot, released slots without a
  // refill go empty, and every step bumps the wrapping step counter.
  always_comb begin
    got_d       = got_q;
    hold_d      = hold_q;
    stepCount_d = stepCount_q;
    for (int i = 0; i < nports; i++) begin
      if (accept[i]) begin
        hold_d[i*width +: width] = IN_DATA[i*width +: width];
        got_d[i]                 = 1'b1;
      end else if (stepFire) begin
        got_d[i] = 1'b0;
      end
    end
    if (stepFire) begin
      stepCount_d = stepCount_q + 16'd1;
    end
  end

  // State registers; reset discards any partially collected bundle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      got_q       <= '0;
      hold_q      <= '0;
      stepCount_q <= '0;
    end else begin
      got_q       <= got_d;
      hold_q      <= hold_d;
      stepCount_q <= stepCount_d;
    end
  end

  assign IN_CONSUMED = accept;
  assign OUT_READY   = bundleReady;
  assign OUT_FIRE    = stepFire;
  assign OUT_DATA    = hold_q;
  assign STEP_COUNT  = stepCount_q;

endmodule

// File: tb/tb_multi_port_collector.sv
// tb_multi_port_collector
// Self-checking bench for multi_port_collector (2 channels x 8 bits).
module tb_multi_port_collector;

  localparam int NP = 2;
  localparam int W  = 8;
  localparam int DW = NP*W;

  logic          clk;
  logic          rstN;
  logic [DW-1:0] inData;
  logic [NP-1:0] inValid;
  logic [NP-1:0] inConsumed;
  logic          stepEn;
  logic          outReady;
  logic          outFire;
  logic [DW-1:0] outData;
  logic [15:0]   stepCount;

  int checks = 0;
  int errors = 0;

  multi_port_collector #(.width(W), .nports(NP)) dut (
    .CLK        (clk),
    .RST_N      (rstN),
    .IN_DATA    (inData),
    .IN_VALID   (inValid),
    .IN_CONSUMED(inConsumed),
    .STEP_EN    (stepEn),
    .OUT_READY  (outReady),
    .OUT_FIRE   (outFire),
    .OUT_DATA   (outData),
    .STEP_COUNT (stepCount)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: each channel is a slot that is either empty or holds
  // one token; a step empties every slot and counts one more completed step.
  bit          mGot[NP];
  logic [W-1:0] mHold[NP];
  int          mCount;

  function automatic void modelPredict(output logic [NP-1:0] c, output logic r,
                                       output logic f, output logic [DW-1:0] d,
                                       output logic [15:0] cnt);
    r = 1'b1;
    for (int i = 0; i < NP; i++) if (!mGot[i]) r = 1'b0;
    f = r && stepEn && rstN;
    for (int i = 0; i < NP; i++) begin
      c[i] = rstN && inValid[i] && (!mGot[i] || f);
      d[i*W +: W] = mHold[i];
    end
    cnt = 16'(mCount);
  endfunction

  function automatic void modelStep();
    logic [NP-1:0] c;
    logic          r;
    logic          f;
    logic [DW-1:0] d;
    logic [15:0]   cnt;
    modelPredict(c, r, f, d, cnt);
    if (!rstN) begin
      for (int i = 0; i < NP; i++) begin
        mGot[i]  = 1'b0;
        mHold[i] = '0;
      end
      mCount = 0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (c[i]) begin
          mHold[i] = inData[i*W +: W];
          mGot[i]  = 1'b1;
        end else if (f) begin
          mGot[i] = 1'b0;
        end
      end
      if (f) mCount = (mCount + 1) % 65536;
    end
  endfunction

  // Drive one cycle's inputs, then let combinational outputs settle to the
  // mid-cycle sampling point.
  task automatic applyStimulus(input logic r, input logic en,
                               input logic [NP-1:0] v, input logic [DW-1:0] d);
    rstN    = r;
    stepEn  = en;
    inValid = v;
    inData  = d;
    #4;
  endtask

  // Compare every DUT output with the given expectations.
  task automatic checkOutput(input string name, input logic [NP-1:0] eCons,
                             input logic eReady, input logic eFire,
                             input logic [DW-1:0] eData, input logic [15:0] eCount);
    checks++;
    if (inConsumed !== eCons) begin
      errors++;
      $display("[TB] FAIL %s.IN_CONSUMED actual=%b required=%b", name, inConsumed, eCons);
    end
    checks++;
    if (outReady !== eReady) begin
      errors++;
      $display("[TB] FAIL %s.OUT_READY actual=%b required=%b", name, outReady, eReady);
    end
    checks++;
    if (outFire !== eFire) begin
      errors++;
      $display("[TB] FAIL %s.OUT_FIRE actual=%b required=%b", name, outFire, eFire);
    end
    checks++;
    if (outData !== eData) begin
      errors++;
      $display("[TB] FAIL %s.OUT_DATA actual=%h required=%h", name, outData, eData);
    end
    checks++;
    if (stepCount !== eCount) begin
      errors++;
      $display("[TB] FAIL %s.STEP_COUNT actual=%h required=%h", name, stepCount, eCount);
    end
  endtask

  // Check against the reference model's prediction for the current cycle.
  task automatic checkModel(input string name);
    logic [NP-1:0] c;
    logic          r;
    logic          f;
    logic [DW-1:0] d;
    logic [15:0]   cnt;
    modelPredict(c, r, f, d, cnt);
    checkOutput(name, c, r, f, d, cnt);
  endtask

  // Commit the cycle: advance the model and move just past the next edge.
  task automatic advance();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rstN;
    logic          stepEn;
    logic [NP-1:0] valid;
    logic [DW-1:0] data;
    logic [NP-1:0] expCons;
    logic          expReady;
    logic          expFire;
    logic [DW-1:0] expData;
    logic [15:0]   expCount;
  } vec_t;

  function automatic vec_t mkVec(logic r, logic en, logic [NP-1:0] v, logic [DW-1:0] d,
                                 logic [NP-1:0] ec, logic er, logic ef,
                                 logic [DW-1:0] ed, logic [15:0] ecnt);
    vec_t t;
    t.rstN = r; t.stepEn = en; t.valid = v; t.data = d;
    t.expCons = ec; t.expReady = er; t.expFire = ef; t.expData = ed; t.expCount = ecnt;
    return t;
  endfunction

  vec_t vecs[21];

  initial begin
    logic [DW-1:0] streamData;
    logic [DW-1:0] prevData;

    // Reset held with all channels valid; then skewed arrival, re-presented
    // token on a filled channel, reset mid-step, and backpressure release.
    vecs[0]  = mkVec(1'b0, 1'b1, 2'b11, 16'hFFFF, 2'b00, 1'b0, 1'b0, 16'h0000, 16'd0);
    vecs[1]  = mkVec(1'b0, 1'b1, 2'b11, 16'hFFFF, 2'b00, 1'b0, 1'b0, 16'h0000, 16'd0);
    vecs[2]  = mkVec(1'b1, 1'b1, 2'b01, 16'h0011, 2'b01, 1'b0, 1'b0, 16'h0000, 16'd0);
    vecs[3]  = mkVec(1'b1, 1'b1, 2'b01, 16'h0033, 2'b00, 1'b0, 1'b0, 16'h0011, 16'd0);
    vecs[4]  = mkVec(1'b1, 1'b1, 2'b01, 16'h0033, 2'b00, 1'b0, 1'b0, 16'h0011, 16'd0);
    vecs[5]  = mkVec(1'b1, 1'b1, 2'b11, 16'h2233, 2'b10, 1'b0, 1'b0, 16'h0011, 16'd0);
    vecs[6]  = mkVec(1'b1, 1'b1, 2'b01, 16'h0033, 2'b01, 1'b1, 1'b1, 16'h2211, 16'd0);
    vecs[7]  = mkVec(1'b1, 1'b1, 2'b00, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h2233, 16'd1);
    vecs[8]  = mkVec(1'b0, 1'b1, 2'b00, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h2233, 16'd1);
    vecs[9]  = mkVec(1'b1, 1'b1, 2'b10, 16'h4400, 2'b10, 1'b0, 1'b0, 16'h0000, 16'd0);
    vecs[10] = mkVec(1'b1, 1'b1, 2'b01, 16'h0055, 2'b01, 1'b0, 1'b0, 16'h4400, 16'd0);
    vecs[11] = mkVec(1'b1, 1'b1, 2'b00, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h4455, 16'd0);
    vecs[12] = mkVec(1'b1, 1'b1, 2'b00, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h4455, 16'd1);
    vecs[13] = mkVec(1'b1, 1'b0, 2'b11, 16'h6677, 2'b11, 1'b0, 1'b0, 16'h4455, 16'd1);
    for (int i = 14; i <= 18; i++)
      vecs[i] = mkVec(1'b1, 1'b0, 2'b11, 16'h8899, 2'b00, 1'b1, 1'b0, 16'h6677, 16'd1);
    vecs[19] = mkVec(1'b1, 1'b1, 2'b11, 16'h8899, 2'b11, 1'b1, 1'b1, 16'h6677, 16'd1);
    vecs[20] = mkVec(1'b1, 1'b0, 2'b00, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h8899, 16'd2);

    for (int i = 0; i < NP; i++) begin
      mGot[i]  = 1'b0;
      mHold[i] = '0;
    end
    mCount = 0;

    // Initial reset edge brings the registers out of the unknown state.
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    advance();

    $display("[TB] table vectors");
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].stepEn, vecs[i].valid, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].expCons, vecs[i].expReady,
                  vecs[i].expFire, vecs[i].expData, vecs[i].expCount);
      advance();
    end

    // Back-to-back streaming: drain the held bundle, then feed both channels
    // every cycle; every cycle after the first fires with last cycle's data.
    $display("[TB] streaming");
    applyStimulus(1'b1, 1'b1, 2'b00, 16'h0000);
    checkOutput("drain", 2'b00, 1'b1, 1'b1, 16'h8899, 16'd2);
    advance();
    prevData = 16'h8899;
    for (int k = 0; k <= 10; k++) begin
      streamData = {8'(8'hA0 + k), 8'(8'h10 + k)};
      applyStimulus(1'b1, 1'b1, 2'b11, streamData);
      checkOutput($sformatf("stream%0d", k), 2'b11, (k > 0), (k > 0), prevData,
                  (k > 0) ? 16'(3 + k - 1) : 16'd3);
      prevData = streamData;
      advance();
    end
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0000);
    checkOutput("streamEnd", 2'b00, 1'b1, 1'b0, prevData, 16'd13);
    advance();

    // Randomized traffic against the reference model.
    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
                    NP'($urandom), DW'($urandom));
      checkModel($sformatf("rand%0d", k));
      advance();
    end

    // Counter wrap: reset, fill, then 65535 fires reach 0xFFFF and the next
    // fire wraps the counter to zero.
    $display("[TB] counter wrap");
    applyStimulus(1'b0, 1'b0, 2'b00, 16'h0000);
    advance();
    for (int k = 0; k < 65536; k++) begin
      applyStimulus(1'b1, 1'b1, 2'b11, 16'h5AA5);
      advance();
    end
    applyStimulus(1'b1, 1'b1, 2'b11, 16'h5AA5);
    checkOutput("wrapMax", 2'b11, 1'b1, 1'b1, 16'h5AA5, 16'hFFFF);
    advance();
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0000);
    checkOutput("wrapZero", 2'b00, 1'b1, 1'b0, 16'h5AA5, 16'h0000);
    advance();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
